md5_stream_padder: RTL and testbench

//  Streaming MD5/SHA-style message padder; successor to the single-block padder.

---
 rtl/md5_pkg.sv | 28 ++
 rtl/md5_len_field.sv | 22 ++
 rtl/md5_stream_padder.sv | 204 ++++++++++++++++++++
 tb/tb_md5_stream_padder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared definitions for the streaming MD5/SHA-style message padder.
//   BLOCK_W  : padded block width in bits
//   LEN_W    : width of the trailing bit-length field
//   LEN_POS  : bit offset of the length field inside a block
//   PAD_BYTE : marker byte appended right after the message
//   state_t  : padder FSM states (FILL / EMIT / EXTRA)
//   byte_swap64 : reverses byte order of a 64-bit word
package md5_pkg;

  localparam int         BLOCK_W  = 512;
  localparam int         LEN_W    = 64;
  localparam int         LEN_POS  = 448;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    EXTRA = 2'd2
  } state_t;

  function automatic logic [63:0] byte_swap64(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = v[56-8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/md5_len_field.sv
// Combinational formatter for the 64-bit length field of a padded block.
// The returned vector is placed MSB-first at block bits 448..511, so
// field[63:56] lands in byte 56.
//   len    in  64  message length in bits
//   field  out 64  length field in the configured byte order
// Parameter LEN_LE: 1 = little-endian (MD5), 0 = big-endian (SHA-1/2).
module md5_len_field
  import md5_pkg::*;
#(
  parameter int LEN_LE = 1
) (
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] field
);

  if (LEN_LE != 0) begin : g_le
    assign field = byte_swap64(len);
  end else begin : g_be
    assign field = len;
  end

endmodule

// File: rtl/md5_stream_padder.sv
// Streaming MD5/SHA-style message padder.
// Collects a WORD_W-bit word stream into 512-bit blocks and appends the
// 0x80 marker, zero fill and 64-bit bit length; adds an extra block when
// the tail leaves no room for the length field.
// Ports:
//   clk, h_rst_n (async, active low), s_rst (sync, active high abort)
//   in_valid/in_ready/in_data/in_last  : message word stream
//   in_bytes                           : valid bytes in last word (MD5_PAD_BYTE_EN only)
//   out_valid/out_ready/out_block/out_last : padded block stream, bit 0 first
//   busy                               : message in progress
// Build option: define MD5_PAD_BYTE_EN to add in_bytes and byte-granular
// message lengths; otherwise every word is full.
module md5_stream_padder
  import md5_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LEN_LE = 1
) (
  input  logic                      clk,
  input  logic                      h_rst_n,
  input  logic                      s_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_data,
  input  logic                      in_last,
`ifdef MD5_PAD_BYTE_EN
  input  logic [$clog2(WORD_W/8):0] in_bytes,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [0:BLOCK_W-1]        out_block,
  output logic                      out_last,
  output logic                      busy
);

  localparam int BYTES = WORD_W / 8;
  localparam int WORDS = BLOCK_W / WORD_W;
  localparam int NB_W  = $clog2(BYTES) + 1;
  localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int POS_W = $clog2(BLOCK_W) + 1;

  state_t             state, state_n;
  logic [0:BLOCK_W-1] blk_q, blk_n;
  logic               last_q, last_n;
  logic               xpend_q, xpend_n;   // extra length block still owed
  logic               xmark_q, xmark_n;   // extra block must carry the marker
  logic               busy_q, busy_n;
  logic [WC_W-1:0]    wc_q, wc_n;
  logic [LEN_W-1:0]   len_q, len_n;

  logic [NB_W-1:0]    nbytes;
  logic [WORD_W-1:0]  word_m;
  logic [POS_W-1:0]   off, p_end;
  logic [LEN_W-1:0]   len_next, len_src, len_fld;

`ifdef MD5_PAD_BYTE_EN
  assign nbytes = in_last ? in_bytes : NB_W'(BYTES);
`else
  assign nbytes = NB_W'(BYTES);
`endif

  assign off      = POS_W'(wc_q) * POS_W'(WORD_W);
  assign p_end    = off + (POS_W'(nbytes) << 3);
  assign len_next = len_q + (LEN_W'(nbytes) << 3);

  // In FILL the field must include the word being accepted; in EMIT the
  // length register is already final and in_data is don't-care.
  assign len_src  = (state == FILL) ? len_next : len_q;

  md5_len_field #(.LEN_LE(LEN_LE)) u_len_field (
    .len   (len_src),
    .field (len_fld)
  );

  // Bytes beyond the valid count are zeroed so junk never reaches a block.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave a latch behind.
    word_m = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (NB_W'(i) < nbytes) word_m[WORD_W-1-8*i -: 8] = in_data[WORD_W-1-8*i -: 8];
    end
  end

  always_comb begin
    state_n = state;
    blk_n   = blk_q;
    last_n  = last_q;
    xpend_n = xpend_q;
    xmark_n = xmark_q;
    busy_n  = busy_q;
    wc_n    = wc_q;
    len_n   = len_q;

    case (state)
      FILL: begin
        if (in_valid) begin
          // Clearing on the first word guarantees everything past the
          // marker is already zero when the block closes.
          if (wc_q == '0) blk_n = '0;
          for (int w = 0; w < WORDS; w++) begin
            if (wc_q == WC_W'(w)) blk_n[w*WORD_W +: WORD_W] = word_m;
          end
          len_n  = len_next;
          wc_n   = wc_q + 1'b1;
          busy_n = 1'b1;

          if (in_last) begin
            for (int k = 0; k < BLOCK_W / 8; k++) begin
              if (p_end == POS_W'(8*k)) blk_n[8*k +: 8] = PAD_BYTE;
            end
            if (p_end < POS_W'(LEN_POS)) begin
              blk_n[LEN_POS +: LEN_W] = len_fld;
              last_n  = 1'b1;
              xpend_n = 1'b0;
              xmark_n = 1'b0;
            end else begin
              last_n  = 1'b0;
              xpend_n = 1'b1;
              xmark_n = (p_end == POS_W'(BLOCK_W));
            end
            wc_n    = '0;
            state_n = EMIT;
          end else if (wc_q == WC_W'(WORDS - 1)) begin
            last_n  = 1'b0;
            xpend_n = 1'b0;
            xmark_n = 1'b0;
            wc_n    = '0;
            state_n = EMIT;
          end
        end
      end

      EMIT, EXTRA: begin
        if (out_ready) begin
          if (state == EMIT && xpend_q) begin
            blk_n = '0;
            if (xmark_q) blk_n[0 +: 8] = PAD_BYTE;
            blk_n[LEN_POS +: LEN_W] = len_fld;
            last_n  = 1'b1;
            xpend_n = 1'b0;
            xmark_n = 1'b0;
            state_n = EXTRA;
          end else begin
            wc_n    = '0;
            state_n = FILL;
            if (last_q) begin
              len_n  = '0;
              busy_n = 1'b0;
              last_n = 1'b0;
            end
          end
        end
      end

      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge h_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!h_rst_n)  state <= FILL;
    else if (s_rst) state <= FILL;
    else            state <= state_n;
  end

  always_ff @(posedge clk or negedge h_rst_n) begin
    if (!h_rst_n) begin
      // NOTE: the wide block register is reset on purpose: out_block must
      // read zero after reset, not whatever the last message left there.
      blk_q   <= '0;
      last_q  <= 1'b0;
      xpend_q <= 1'b0;
      xmark_q <= 1'b0;
      busy_q  <= 1'b0;
      wc_q    <= '0;
      len_q   <= '0;
    end else if (s_rst) begin
      blk_q   <= '0;
      last_q  <= 1'b0;
      xpend_q <= 1'b0;
      xmark_q <= 1'b0;
      busy_q  <= 1'b0;
      wc_q    <= '0;
      len_q   <= '0;
    end else begin
      blk_q   <= blk_n;
      last_q  <= last_n;
      xpend_q <= xpend_n;
      xmark_q <= xmark_n;
      busy_q  <= busy_n;
      wc_q    <= wc_n;
      len_q   <= len_n;
    end
  end

  assign in_ready  = (state == FILL);
  assign out_valid = (state != FILL);
  assign out_block = blk_q;
  assign out_last  = last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_md5_stream_padder.sv
// Self-checking bench for md5_stream_padder (WORD_W=32). Two instances share
// the inputs: one little-endian length (MD5), one big-endian (SHA).
// Expected blocks come from a byte-level padding model: message bytes, 0x80,
// zeros until length = 56 mod 64, then eight length bytes.
module tb_md5_stream_padder;
  import md5_pkg::*;

  localparam int WORD_W = 32;

  logic               clk = 1'b0;
  logic               h_rst_n = 1'b0;
  logic               s_rst = 1'b0;
  logic               in_valid = 1'b0;
  logic [WORD_W-1:0]  in_data = '0;
  logic               in_last = 1'b0;
  logic [2:0]         in_bytes = '0;
  logic               out_ready = 1'b0;

  logic               in_ready, out_valid, out_last, busy;
  logic [0:511]       out_block;
  logic               in_ready_be, out_valid_be, out_last_be, busy_be;
  logic [0:511]       out_block_be;

  int checks = 0;
  int errors = 0;

  byte unsigned msg_q[$];
  logic [0:511] exp_le[$], exp_be[$], got_le[$], got_be[$];

  always #5 clk = ~clk;

  md5_stream_padder #(.WORD_W(WORD_W), .LEN_LE(1)) dut_le (
    .clk(clk), .h_rst_n(h_rst_n), .s_rst(s_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
`ifdef MD5_PAD_BYTE_EN
    .in_bytes(in_bytes),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_last(out_last), .busy(busy)
  );

  md5_stream_padder #(.WORD_W(WORD_W), .LEN_LE(0)) dut_be (
    .clk(clk), .h_rst_n(h_rst_n), .s_rst(s_rst),
    .in_valid(in_valid), .in_ready(in_ready_be), .in_data(in_data), .in_last(in_last),
`ifdef MD5_PAD_BYTE_EN
    .in_bytes(in_bytes),
`endif
    .out_valid(out_valid_be), .out_ready(out_ready), .out_block(out_block_be),
    .out_last(out_last_be), .busy(busy_be)
  );

  // Reference padding on whole bytes, then split into 64-byte blocks.
  function automatic void build_exp(input int n);
    byte unsigned pl[$], pb[$];
    logic [63:0]  bits;
    logic [0:511] v;
    bits = 64'(n) << 3;
    for (int i = 0; i < n; i++) begin
      pl.push_back(msg_q[i]);
      pb.push_back(msg_q[i]);
    end
    pl.push_back(8'h80);
    pb.push_back(8'h80);
    while (pl.size() % 64 != 56) begin
      pl.push_back(8'h00);
      pb.push_back(8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      pl.push_back(bits[8*i +: 8]);
      pb.push_back(bits[56-8*i +: 8]);
    end
    exp_le.delete();
    exp_be.delete();
    for (int b = 0; b < pl.size() / 64; b++) begin
      for (int k = 0; k < 64; k++) v[8*k +: 8] = pl[64*b+k];
      exp_le.push_back(v);
      for (int k = 0; k < 64; k++) v[8*k +: 8] = pb[64*b+k];
      exp_be.push_back(v);
    end
  endfunction

  task automatic make_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(255)));
  endtask

  // Streams msg_q with random input gaps and output back-pressure, checking
  // every presented block against the model. stall = minimum cycles each
  // block is held with out_ready low before it is taken.
  task automatic run_msg(input int n, input bit zero_tail, input int stall);
    int  nwords, w, blk, cyc, wait_cnt, idx;
    bit  done;
    build_exp(n);
    got_le.delete();
    got_be.delete();
    nwords   = zero_tail ? (n / 4 + 1) : ((n + 3) / 4);
    w        = 0;
    blk      = 0;
    cyc      = 0;
    wait_cnt = 0;
    done     = 1'b0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'b0;
      if (w > 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid: got %b want 1", busy);
        end
      end
      if (out_valid) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid_be !== 1'b1) begin
          errors++;
          $display("FAIL ready_during_emit: in_ready %b out_valid_be %b want 0/1", in_ready, out_valid_be);
        end
        checks++;
        if (out_block !== exp_le[blk]) begin
          errors++;
          $display("FAIL block_le[%0d]: got %h want %h", blk, out_block, exp_le[blk]);
        end
        checks++;
        if (out_block_be !== exp_be[blk]) begin
          errors++;
          $display("FAIL block_be[%0d]: got %h want %h", blk, out_block_be, exp_be[blk]);
        end
        checks++;
        if (out_last !== (blk == exp_le.size() - 1) || out_last_be !== out_last) begin
          errors++;
          $display("FAIL out_last[%0d]: got %b/%b want %b", blk, out_last, out_last_be,
                   (blk == exp_le.size() - 1));
        end
        if (wait_cnt >= stall && $urandom_range(3) != 0) begin
          out_ready = 1'b1;
          got_le.push_back(out_block);
          got_be.push_back(out_block_be);
          blk++;
          wait_cnt = 0;
          if (blk == exp_le.size()) done = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = $urandom();
      in_bytes = 3'($urandom_range(4));
      if (w < nwords && $urandom_range(4) != 0) begin
        in_valid = 1'b1;
        in_last  = (w == nwords - 1);
        for (int i = 0; i < 4; i++) begin
          idx = 4 * w + i;
          if (idx < n) in_data[31-8*i -: 8] = msg_q[idx];
        end
        if (in_last) in_bytes = 3'(n - 4 * (nwords - 1));
        if (in_ready) w++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: got %0d blocks want %0d", blk, exp_le.size());
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || busy_be !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_msg: busy %b out_valid %b want 0 0", busy, out_valid);
    end
  endtask

  task automatic check_abcd_block(input string tag);
    checks++;
    if (got_le.size() != 1) begin
      errors++;
      $display("FAIL %s_count: got %0d blocks want 1", tag, got_le.size());
    end else if (got_le[0][0 +: 40] !== 40'h6162636480 || got_le[0][40 +: 408] !== '0 ||
                 got_le[0][448 +: 64] !== 64'h2000000000000000) begin
      errors++;
      $display("FAIL %s_block: got %h want 6162636480..20 00..", tag, got_le[0]);
    end
  endtask

  task automatic test_reset();
    h_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_block !== '0) begin
      errors++;
      $display("FAIL reset_state: valid %b last %b busy %b block %h want all 0",
               out_valid, out_last, busy, out_block);
    end
    h_rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_ready_be !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_abcd();
    msg_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    run_msg(4, 1'b0, 0);
    check_abcd_block("abcd");
  endtask

  task automatic test_sixty();
    make_msg(60);
    run_msg(60, 1'b0, 0);
    checks++;
    if (got_le.size() != 2) begin
      errors++;
      $display("FAIL sixty_count: got %0d want 2", got_le.size());
    end else if (got_le[0][480 +: 32] !== 32'h80000000 || got_le[1][0 +: 448] !== '0 ||
                 got_le[1][448 +: 64] !== 64'hE001000000000000) begin
      errors++;
      $display("FAIL sixty_fields: tail %h len %h want 80000000 e001000000000000",
               got_le[0][480 +: 32], got_le[1][448 +: 64]);
    end
  endtask

  task automatic test_sixty_four();
    make_msg(64);
    run_msg(64, 1'b0, 0);
    checks++;
    if (got_le.size() != 2 || got_be.size() != 2) begin
      errors++;
      $display("FAIL sixty_four_count: got %0d want 2", got_le.size());
    end else if (got_le[1][0 +: 8] !== 8'h80 || got_le[1][448 +: 16] !== 16'h0002 ||
                 got_be[1][496 +: 16] !== 16'h0200) begin
      errors++;
      $display("FAIL sixty_four_fields: marker %h le56 %h be62 %h want 80 0002 0200",
               got_le[1][0 +: 8], got_le[1][448 +: 16], got_be[1][496 +: 16]);
    end
  endtask

  task automatic test_stall();
    make_msg(60);
    run_msg(60, 1'b0, 5);
    msg_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    run_msg(4, 1'b0, 5);
    check_abcd_block("stall_abcd");
  endtask

  task automatic send_partial(input int nw);
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL partial_ready: got %b want 1", in_ready);
      end
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = $urandom();
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_partial(5);
    h_rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hrst_mid: valid %b busy %b want 0 0", out_valid, busy);
    end
    @(negedge clk);
    h_rst_n = 1'b1;
    msg_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    run_msg(4, 1'b0, 0);
    check_abcd_block("hrst_abcd");

    send_partial(5);
    s_rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL srst_mid: valid %b busy %b want 0 0", out_valid, busy);
    end
    msg_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    run_msg(4, 1'b0, 0);
    check_abcd_block("srst_abcd");
  endtask

  // Soft reset with a block pending and out_ready high: the reset wins.
  task automatic test_srst_pending();
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 32'h61626364;
    in_bytes = 3'd4;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL srst_pend_valid: got %b want 1", out_valid);
    end
    out_ready = 1'b1;
    s_rst     = 1'b1;
    @(negedge clk);
    s_rst     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_block !== '0) begin
      errors++;
      $display("FAIL srst_pend_clear: valid %b last %b busy %b block %h want 0",
               out_valid, out_last, busy, out_block);
    end
  endtask

`ifdef MD5_PAD_BYTE_EN
  task automatic test_byte_en();
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(3, 1'b0, 0);
    checks++;
    if (got_le.size() != 1) begin
      errors++;
      $display("FAIL abc_count: got %0d want 1", got_le.size());
    end else if (got_le[0][0 +: 32] !== 32'h61626380 || got_le[0][448 +: 8] !== 8'h18) begin
      errors++;
      $display("FAIL abc_fields: head %h len %h want 61626380 18",
               got_le[0][0 +: 32], got_le[0][448 +: 8]);
    end
    msg_q.delete();
    run_msg(0, 1'b1, 0);
    make_msg(56);
    run_msg(56, 1'b1, 1);
    make_msg(64);
    run_msg(64, 1'b1, 0);
    make_msg(57);
    run_msg(57, 1'b0, 0);
  endtask
`endif

  task automatic test_random();
    int  n;
    bit  zt;
    for (int t = 0; t < 25; t++) begin
`ifdef MD5_PAD_BYTE_EN
      n  = $urandom_range(160);
      zt = (n % 4 == 0) && ((n == 0) || ($urandom_range(1) == 1));
`else
      n  = 4 * $urandom_range(1, 40);
      zt = 1'b0;
`endif
      make_msg(n);
      run_msg(n, zt, $urandom_range(2));
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      make_msg(4 * (13 + t));
      run_msg(4 * (13 + t), 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_abcd();
    test_sixty();
    test_sixty_four();
    test_stall();
    test_reset_mid();
    test_srst_pending();
`ifdef MD5_PAD_BYTE_EN
    test_byte_en();
`endif
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
